// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner.
// Key codes index a 16-bit snapshot where bit row*4+col is set for a pressed key.
package keypad_pkg;

  localparam int KP_ROWS   = 4;
  localparam int KP_COLS   = 4;
  localparam int KP_CODE_W = 4;

  localparam logic [KP_COLS-1:0] COL_IDLE = 4'b1110;

  typedef struct packed {
    logic                 valid;
    logic [KP_CODE_W-1:0] code;
  } key_hit_t;

  // valid only when exactly one bit is set; code is then that bit's index
  function automatic key_hit_t onehot16(input logic [KP_ROWS*KP_COLS-1:0] v);
    key_hit_t    h;
    int unsigned cnt;
    h.valid = 1'b0;
    h.code  = '0;
    cnt     = 0;
    for (int i = 0; i < KP_ROWS*KP_COLS; i++) begin
      if (v[i]) begin
        cnt    = cnt + 1;
        h.code = KP_CODE_W'(i);
      end
    end
    h.valid = (cnt == 1);
    return h;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Matrix and key-event signals of the keypad scanner.
// The scanner takes the master side; the matrix/consumer takes the slave side.
interface keypad_if;
  import keypad_pkg::*;

  logic [KP_ROWS-1:0]   row_in;
  logic [KP_COLS-1:0]   col_out;
  logic                 key_valid;
  logic [KP_CODE_W-1:0] key_code;
  logic                 key_down;

  modport master (input row_in, output col_out, key_valid, key_code, key_down);
  modport slave  (output row_in, input col_out, key_valid, key_code, key_down);
endinterface

// File: rtl/scan_strobe.sv
// One-cycle clock-enable generator: tick is high on every DIV-th clock.
// Used instead of a divided clock so everything stays on clk.
module scan_strobe #(
  parameter int DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column sequencer, full-matrix snapshot,
// scan-level debounce and single-key event generation.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int            KN         = KP_ROWS * KP_COLS;
  localparam int            SW         = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  logic tick;

  scan_strobe #(.DIV(SCAN_DIV)) u_strobe (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [1:0]           col_idx_q, col_idx_d;
  logic [KN-1:0]        partial_q, partial_d;
  logic [KN-1:0]        prev_q, prev_d;
  logic [KN-1:0]        deb_q, deb_d;
  logic [SW-1:0]        stable_q, stable_d;
  logic                 accept_q, accept_d;
  logic                 key_valid_q, key_valid_d;
  logic [KP_CODE_W-1:0] key_code_q, key_code_d;
  logic                 key_down_q, key_down_d;

  logic [KN-1:0]        scan_new;
  key_hit_t             hit;

  always_comb begin
    col_idx_d   = col_idx_q;
    partial_d   = partial_q;
    prev_d      = prev_q;
    deb_d       = deb_q;
    stable_d    = stable_q;
    accept_d    = 1'b0;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;

    // current column merged into the partial scan at bit row*4+col
    scan_new = partial_q;
    for (int r = 0; r < KP_ROWS; r++) begin
      scan_new[r*KP_COLS + int'(col_idx_q)] = ~kp.row_in[r];
    end

    if (tick) begin
      col_idx_d = col_idx_q + 2'd1;
      partial_d = scan_new;
      if (col_idx_q == 2'd3) begin
        prev_d = scan_new;
        if (scan_new == prev_q)
          stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
        else
          stable_d = SW'(1);
        accept_d = (stable_d == STABLE_MAX);
      end
    end

    // prev_q holds the just-completed scan; no tick can intervene since SCAN_DIV >= 2
    hit = onehot16(prev_q);
    if (accept_q) begin
      deb_d      = prev_q;
      key_down_d = hit.valid;
      if (hit.valid && (prev_q != deb_q)) begin
        key_valid_d = 1'b1;
        key_code_d  = hit.code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_idx_q   <= '0;
      partial_q   <= '0;
      prev_q      <= '0;
      deb_q       <= '0;
      stable_q    <= '0;
      accept_q    <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_down_q  <= 1'b0;
    end else begin
      col_idx_q   <= col_idx_d;
      partial_q   <= partial_d;
      prev_q      <= prev_d;
      deb_q       <= deb_d;
      stable_q    <= stable_d;
      accept_q    <= accept_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_down_q  <= key_down_d;
    end
  end

  assign kp.col_out   = ~(4'b0001 << col_idx_q);
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix, behavioural scan/debounce model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_keypad_scanner;

  localparam int DIV  = 4;
  localparam int DEB  = 2;
  localparam int SCAN = 4 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_if kp();

  keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  // pressed[r*4+c] = key at row r, column c is held down
  logic [15:0] pressed = '0;
  logic [3:0]  row_v;

  always_comb begin
    row_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.col_out[c]) row_v[r] = 1'b0;
  end
  assign kp.row_in = row_v;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          t = 0;           // clocks since reset released
  logic [15:0] m_partial = '0;
  logic [15:0] m_hist[$];       // most recent completed scans
  logic [15:0] m_deb = '0;
  logic        m_pend = 1'b0;
  logic [15:0] m_acc = '0;
  logic [3:0]  exp_col = 4'b1110;
  logic        exp_valid = 1'b0;
  logic [3:0]  exp_code = '0;
  logic        exp_down = 1'b0;

  function automatic int low_index(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      t = 0; m_partial = '0; m_hist.delete(); m_deb = '0; m_pend = 1'b0;
      exp_valid = 1'b0; exp_code = '0; exp_down = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (m_pend) begin
        m_pend = 1'b0;
        if (m_acc != m_deb) begin
          if ($countones(m_acc) == 1) begin
            exp_valid = 1'b1;
            exp_code  = 4'(low_index(m_acc));
          end
          m_deb = m_acc;
        end
        exp_down = ($countones(m_deb) == 1);
      end
      if (t % DIV == DIV - 1) begin
        int c;
        bit same;
        c = (t / DIV) % 4;
        for (int r = 0; r < 4; r++) m_partial[r*4+c] = ~kp.row_in[r];
        if (c == 3) begin
          m_hist.push_back(m_partial);
          if (m_hist.size() > DEB) void'(m_hist.pop_front());
          same = (m_hist.size() == DEB);
          foreach (m_hist[i]) if (m_hist[i] != m_partial) same = 1'b0;
          if (same) begin
            m_pend = 1'b1;
            m_acc  = m_partial;
          end
        end
      end
      t++;
    end
    begin
      logic [3:0] one;
      one = 4'b0001;
      exp_col = ~(one << ((t / DIV) % 4));
    end
  end

  // ---------------- per-cycle compare + pulse monitor ----------------
  int         pulses = 0;
  logic [3:0] last_code = '0;

  initial forever begin
    @(negedge clk);
    check("col_out",   kp.col_out,   exp_col);
    check("key_valid", kp.key_valid, exp_valid);
    check("key_code",  kp.key_code,  exp_code);
    check("key_down",  kp.key_down,  exp_down);
    if (kp.key_valid === 1'b1) begin
      pulses++;
      last_code = kp.key_code;
    end
  end

  task automatic wait_phase(input int ph);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2*SCAN && !found; i++) begin
      @(negedge clk);
      if (t % SCAN == ph) found = 1'b1;
    end
    check("align_found", found, 1);
  endtask

  task automatic wait_pulse(input int budget, input int p0, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (lat < 0 && pulses != p0) lat = i;
    end
  endtask

  logic [3:0] col_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    int p0;
    int lat;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col",   kp.col_out,   4'b1110);
    check("rst_valid", kp.key_valid, 0);
    check("rst_code",  kp.key_code,  0);
    check("rst_down",  kp.key_down,  0);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("col_step", kp.col_out, col_seq[k]);
      repeat (DIV - 1) @(negedge clk);
    end

    p0 = pulses;
    repeat (200) @(negedge clk);
    check("idle_pulses", pulses - p0, 0);

    // row2/col1 -> code 9
    p0 = pulses;
    pressed[9] = 1'b1;
    wait_pulse(300, p0, lat);
    check("k9_pulses", pulses - p0, 1);
    check("k9_code", last_code, 9);
    check("k9_down", kp.key_down, 1);
    check("k9_latency_ok", (lat > 0 && lat <= 3*SCAN + 1) ? 1 : 0, 1);
    pressed = '0;
    repeat (100) @(negedge clk);
    check("k9_rel_down", kp.key_down, 0);
    check("k9_rel_code", kp.key_code, 9);

    // bounce on row3/col0 -> code 12, aligned to the column-0 slot start
    wait_phase(0);
    p0 = pulses;
    for (int i = 0; i < 12; i++) begin
      pressed[12] = (i % 2 == 0);
      repeat (5) @(negedge clk);
    end
    check("bounce_quiet", pulses - p0, 0);
    pressed[12] = 1'b1;
    repeat (100) @(negedge clk);
    check("bounce_pulses", pulses - p0, 1);
    check("bounce_code", last_code, 12);
    check("bounce_down", kp.key_down, 1);
    pressed = '0;
    repeat (100) @(negedge clk);

    // ghosting: keys 0 and 5, then reduce to 5
    p0 = pulses;
    pressed[0] = 1'b1;
    pressed[5] = 1'b1;
    repeat (100) @(negedge clk);
    check("ghost_pulses", pulses - p0, 0);
    check("ghost_down", kp.key_down, 0);
    pressed[0] = 1'b0;
    repeat (100) @(negedge clk);
    check("reduce_pulses", pulses - p0, 1);
    check("reduce_code", last_code, 5);
    check("reduce_down", kp.key_down, 1);
    pressed = '0;
    repeat (100) @(negedge clk);

    // repeated press of key 15
    p0 = pulses;
    pressed[15] = 1'b1;
    repeat (100) @(negedge clk);
    pressed[15] = 1'b0;
    repeat (100) @(negedge clk);
    check("k15_gap_down", kp.key_down, 0);
    check("k15_gap_code", kp.key_code, 15);
    pressed[15] = 1'b1;
    repeat (100) @(negedge clk);
    check("k15_pulses", pulses - p0, 2);
    check("k15_code", last_code, 15);
    pressed = '0;
    repeat (100) @(negedge clk);

    // reset mid-scan while key 6 is held
    pressed[6] = 1'b1;
    repeat (60) @(negedge clk);
    wait_phase(9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_col", kp.col_out, 4'b1110);
    check("mid_rst_code", kp.key_code, 0);
    check("mid_rst_down", kp.key_down, 0);
    p0 = pulses;
    wait_pulse(49, p0, lat);
    check("k6_fresh_pulse", (lat > 0) ? 1 : 0, 1);
    check("k6_code", last_code, 6);
    pressed = '0;
    repeat (100) @(negedge clk);

    // randomized key activity, checked by the model every cycle
    for (int n = 0; n < 40; n++) begin
      int sel;
      int hold;
      sel  = $urandom_range(0, 9);
      hold = $urandom_range(5, 80);
      if (sel <= 2) pressed = '0;
      else if (sel <= 6) pressed = 16'(1) << $urandom_range(0, 15);
      else if (sel <= 8) pressed = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      else begin
        int k;
        k = $urandom_range(0, 15);
        for (int i = 0; i < 8; i++) begin
          pressed[k] = ~pressed[k];
          repeat ($urandom_range(1, 7)) @(negedge clk);
        end
      end
      repeat (hold) @(negedge clk);
    end
    pressed = '0;
    repeat (100) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
